command_scheduler: RTL

COMMAND_SCHEDULER -- requirements
Module: command_scheduler

---
 rtl/command_scheduler_if.sv | 24 ++
 rtl/command_scheduler.sv | 138 +++++++++++++
 2 files changed

// File: rtl/command_scheduler_if.sv
// Enqueue channel for command pairs into the scheduler queue.
// The producer drives the pair and valid; the scheduler returns ready.
interface command_scheduler_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0] cmd_fetch;
    logic [DATA_WIDTH-1:0] cmd_store;
    logic                  cmd_valid;
    logic                  cmd_ready;

    modport master (
        output cmd_fetch,
        output cmd_store,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd_fetch,
        input  cmd_store,
        input  cmd_valid,
        output cmd_ready
    );
endinterface

// File: rtl/command_scheduler.sv
// Queues fetch/store command pairs and issues them one at a time,
// waiting for both completes with a timeout into a sticky error state.
module command_scheduler #(
    parameter int DATA_WIDTH     = 128,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    command_scheduler_if.slave            cmd,
    output logic [DATA_WIDTH-1:0]         fetcher_command,
    output logic                          fetcher_command_valid,
    input  logic                          fetcher_command_complete,
    output logic [DATA_WIDTH-1:0]         storer_command,
    output logic                          storer_command_valid,
    input  logic                          storer_command_complete,
    input  logic                          err_clear,
    output logic                          busy,
    output logic                          done_pulse,
    output logic                          timeout_err,
    output logic [$clog2(FIFO_DEPTH):0]   queue_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ERR
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] fifo_f [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_s [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  f_done;
    logic                  s_done;
    logic [15:0]           wait_cnt;
    logic                  push;
    logic                  pop;
    logic                  f_seen;
    logic                  s_seen;

    // Ready comes from the registered level only, so a same-cycle pop
    // never opens a slot early.
    assign cmd.cmd_ready = (queue_level < LW'(FIFO_DEPTH));
    assign push = cmd.cmd_valid && cmd.cmd_ready;
    assign pop = (state == IDLE) && (queue_level != '0);
    assign f_seen = f_done || fetcher_command_complete;
    assign s_seen = s_done || storer_command_complete;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_f[wr_ptr] <= cmd.cmd_fetch;
            fifo_s[wr_ptr] <= cmd.cmd_store;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            queue_level           <= '0;
            f_done                <= 1'b0;
            s_done                <= 1'b0;
            wait_cnt              <= '0;
            fetcher_command       <= '0;
            storer_command        <= '0;
            fetcher_command_valid <= 1'b0;
            storer_command_valid  <= 1'b0;
            busy                  <= 1'b0;
            done_pulse            <= 1'b0;
            timeout_err           <= 1'b0;
        end else begin
            fetcher_command_valid <= 1'b0;
            storer_command_valid  <= 1'b0;
            done_pulse            <= 1'b0;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            queue_level <= queue_level + LW'(push) - LW'(pop);
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        fetcher_command       <= fifo_f[rd_ptr];
                        storer_command        <= fifo_s[rd_ptr];
                        fetcher_command_valid <= 1'b1;
                        storer_command_valid  <= 1'b1;
                        busy                  <= 1'b1;
                        state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    f_done   <= f_seen;
                    s_done   <= s_seen;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (f_seen && s_seen) begin
                        done_pulse <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= DONE;
                    end else if (wait_cnt == TMO) begin
                        timeout_err <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= ERR;
                    end else begin
                        f_done <= f_seen;
                        s_done <= s_seen;
                        if (wait_cnt != '1) wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    f_done <= 1'b0;
                    s_done <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                ERR: begin
                    // The timed-out pair is dropped, not retried.
                    if (err_clear) begin
                        timeout_err <= 1'b0;
                        f_done      <= 1'b0;
                        s_done      <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
